pfs_axil_master: RTL
====================

Name: pfs_axil_master

Overview:
- AXI4-Lite initiator that issues single read/write transactions into the daughtercard register map: 6 sectors × 8 registers, 10-bit address, timer at 0x0C0 and above.
- Accepts one command at a time on a valid/ready command port, runs the AXI-Lite handshake, and returns read data and the response code on a valid/ready response port.
- Used by the on-chip sequencer and the loopback bench to drive the sector registers without a processor.

Parameters:
- ADDR_W, 10, AXI address width.
- DATA_W, 32, AXI data width; must be 32.
- TIMEOUT_CYCLES, 1024, bus_clk cycles allowed per transaction before abort.

Ports:
- bus_clk  in  1  bus clock; also used for the AXI side.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address; bits [1:0] ignored and driven 0 on the bus.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  AXI response code, or 2'b10 on timeout.
- rsp_timeout  out  1  transaction aborted by timeout.
- m00_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master, ADDR_W/DATA_W widths. awprot = arprot = 3'b000, wstrb = 4'hF.

Behaviour:
- Reset:
  - All outputs 0; cmd_ready = 0 during reset; FSM in IDLE; timeout counter 0.
  - Reset asserted mid-transaction drops all valids immediately; no response is produced.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, register addr, data and write flag, and clear the counter.
  - Next cycle go to WR or RD_ADDR.
  - cmd_ready is 0 in every other state.
- WR:
  - Assert awvalid, wvalid and bready together in the same cycle.
  - bready stays high from WR entry until the B handshake; the slave requires all three high simultaneously.
  - awvalid drops on the cycle after awready seen; wvalid likewise with wready, tracked independently.
  - When both are accepted, go to WR_RESP.
  - If bvalid arrives in the same cycle as the last ready, capture bresp and go directly to RSP.
- WR_RESP:
  - Wait for bvalid (bready = 1); capture bresp; go to RSP.
  - A bvalid seen as a single-cycle pulse must be captured.
- RD_ADDR:
  - arvalid = 1 until arready; then go to RD_DATA with rready = 1.
- RD_DATA:
  - On rvalid & rready, capture rdata and rresp; go to RSP.
- RSP:
  - rsp_valid = 1; outputs held stable until rsp_ready.
  - Then go to IDLE; a new command can be accepted the cycle after.
- Latency: cmd accept to rsp_valid is at least 3 cycles for a read and at least 3 for a write, against a zero-wait slave.
- Timeout:
  - Counter increments every cycle in WR, WR_RESP, RD_ADDR and RD_DATA.
  - On reaching TIMEOUT_CYCLES-1, all AXI valids/readies drop next cycle; rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0; go to RSP.
  - Counter saturates; never wraps.
- AXI rules:
  - No valid depends combinationally on a ready.
  - Address and data are stable while their valid is high.
  - Outputs are registered.
- Only one outstanding transaction.

Decomposition:
- Package pfs_axil_pkg:
  - FSM state enum.
  - AXI response constants: OKAY = 2'b00, SLVERR = 2'b10.
  - Register-map constants: SECTOR_STRIDE = 0x20; CTRL, STATUS, TX, RX, TX_COUNT, RX_COUNT, RX_PARITY, RX_STPBIT offsets 0x00–0x1C; TIMER_ADDR = 0x0C0.
- No sub-module; the timeout counter is inline.

Test Plan:
- Against the daughtercard slave: write 0xDEADBEEF to 0x028 (sector 1 TX), then read 0x028 -> write rsp_resp = 00; read completes with rsp_resp = 00 and rsp_rdata matching the sector's TX readback.
- Read 0x0C0 twice, 5 ms of ser_clk apart -> second rsp_rdata minus first ≈ 5 (±1).
- Stub slave holding awready = 0 with TIMEOUT_CYCLES = 16 -> rsp_valid in cycle 17 with rsp_resp = 10, rsp_timeout = 1, and awvalid = 0 afterwards.
- Stub slave with wready two cycles before awready, and bvalid as a 1-cycle pulse -> single B capture, rsp_resp = 00, bready high throughout.
- Hold rsp_ready = 0 for 10 cycles -> rsp_rdata stable, cmd_ready = 0, and no new AR/AW issued while cmd_valid stays high.
- Assert rst while arvalid = 1 -> arvalid = 0 asynchronously and rsp_valid = 0; after release, cmd_ready = 1 in the first cycle.

Source files
------------

// File: rtl/pfs_axil_pkg.sv
// Shared types and register-map constants for the daughtercard AXI4-Lite initiator.
package pfs_axil_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // Six sectors of eight 32-bit registers, followed by the timer word.
    localparam logic [9:0] SECTOR_STRIDE = 10'h020;
    localparam logic [9:0] CTRL          = 10'h000;
    localparam logic [9:0] STATUS        = 10'h004;
    localparam logic [9:0] TX            = 10'h008;
    localparam logic [9:0] RX            = 10'h00C;
    localparam logic [9:0] TX_COUNT      = 10'h010;
    localparam logic [9:0] RX_COUNT      = 10'h014;
    localparam logic [9:0] RX_PARITY     = 10'h018;
    localparam logic [9:0] RX_STPBIT     = 10'h01C;
    localparam logic [9:0] TIMER_ADDR    = 10'h0C0;

    function automatic logic [9:0] sector_reg_addr(input logic [2:0] sector, input logic [9:0] offset);
        return 10'(10'(sector) * SECTOR_STRIDE + offset);
    endfunction

endpackage

// File: rtl/pfs_axil_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction, one response out.
// state   | meaning
// IDLE    | ready for a command
// WR      | AW/W offered, bready high
// WR_RESP | AW and W accepted, waiting for B
// RD_ADDR | AR offered
// RD_DATA | waiting for R
// RSP     | response held until consumed
module pfs_axil_master
    import pfs_axil_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                bus_clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    output logic [ADDR_W-1:0]   m00_axi_awaddr,
    output logic [2:0]          m00_axi_awprot,
    output logic                m00_axi_awvalid,
    input  logic                m00_axi_awready,
    output logic [DATA_W-1:0]   m00_axi_wdata,
    output logic [DATA_W/8-1:0] m00_axi_wstrb,
    output logic                m00_axi_wvalid,
    input  logic                m00_axi_wready,
    input  logic [1:0]          m00_axi_bresp,
    input  logic                m00_axi_bvalid,
    output logic                m00_axi_bready,
    output logic [ADDR_W-1:0]   m00_axi_araddr,
    output logic [2:0]          m00_axi_arprot,
    output logic                m00_axi_arvalid,
    input  logic                m00_axi_arready,
    input  logic [DATA_W-1:0]   m00_axi_rdata,
    input  logic [1:0]          m00_axi_rresp,
    input  logic                m00_axi_rvalid,
    output logic                m00_axi_rready
);

    localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                aw_done_q, w_done_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          resp_q;
    logic                timeout_q;
    logic                abort;

    wire cmd_hs  = cmd_valid & cmd_ready;
    wire aw_hs   = m00_axi_awvalid & m00_axi_awready;
    wire w_hs    = m00_axi_wvalid & m00_axi_wready;
    wire b_hs    = m00_axi_bvalid & m00_axi_bready;
    wire ar_hs   = m00_axi_arvalid & m00_axi_arready;
    wire r_hs    = m00_axi_rvalid & m00_axi_rready;
    wire aw_ok   = aw_done_q | aw_hs;
    wire w_ok    = w_done_q | w_hs;
    wire expired = (cnt_q == CNT_LAST);
    wire busy    = (state_q == WR) || (state_q == WR_RESP) ||
                   (state_q == RD_ADDR) || (state_q == RD_DATA);

    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A handshake completing in the expiry cycle wins over the abort.
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            IDLE:    if (cmd_hs) state_d = cmd_write ? WR : RD_ADDR;
            WR: begin
                if (aw_ok && w_ok) state_d = b_hs ? RSP : WR_RESP;
                else if (expired) begin
                    state_d = RSP;
                    abort   = 1'b1;
                end
            end
            WR_RESP: begin
                if (b_hs) state_d = RSP;
                else if (expired) begin
                    state_d = RSP;
                    abort   = 1'b1;
                end
            end
            RD_ADDR: begin
                if (ar_hs) state_d = RD_DATA;
                else if (expired) begin
                    state_d = RSP;
                    abort   = 1'b1;
                end
            end
            RD_DATA: begin
                if (r_hs) state_d = RSP;
                else if (expired) begin
                    state_d = RSP;
                    abort   = 1'b1;
                end
            end
            RSP:     if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready       = (state_q == IDLE) && !rst;
        m00_axi_awvalid = (state_q == WR) && !aw_done_q;
        m00_axi_wvalid  = (state_q == WR) && !w_done_q;
        m00_axi_bready  = (state_q == WR) || (state_q == WR_RESP);
        m00_axi_arvalid = (state_q == RD_ADDR);
        m00_axi_rready  = (state_q == RD_DATA);
        rsp_valid       = (state_q == RSP);
    end

    always_ff @(posedge bus_clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            resp_q    <= OKAY;
            timeout_q <= 1'b0;
        end else begin
            if (cmd_hs) begin
                addr_q    <= cmd_addr & WORD_MASK;
                wdata_q   <= cmd_wdata;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                cnt_q     <= '0;
                rdata_q   <= '0;
                resp_q    <= OKAY;
                timeout_q <= 1'b0;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (busy && !expired) cnt_q <= cnt_q + 1'b1;
            if (b_hs) resp_q <= m00_axi_bresp;
            if (r_hs) begin
                rdata_q <= m00_axi_rdata;
                resp_q  <= m00_axi_rresp;
            end
            if (abort) begin
                rdata_q   <= '0;
                resp_q    <= SLVERR;
                timeout_q <= 1'b1;
            end
        end
    end

    // wstrb follows wvalid so every output sits at zero while idle or in reset.
    assign m00_axi_awaddr = addr_q;
    assign m00_axi_araddr = addr_q;
    assign m00_axi_awprot = 3'b000;
    assign m00_axi_arprot = 3'b000;
    assign m00_axi_wdata  = wdata_q;
    assign m00_axi_wstrb  = {(DATA_W/8){m00_axi_wvalid}};
    assign rsp_rdata      = rdata_q;
    assign rsp_resp       = resp_q;
    assign rsp_timeout    = timeout_q;

endmodule
